// File: rtl/coeff_loader_pkg.sv
// Shared definitions for the coefficient loader: FSM state encoding,
// coefficient slice offset helper and the index counter width rule.
// Ports: none (package only).
package dsp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   // Bit offset of coefficient h[t] inside a packed bank
   function automatic int slice_off(input int t, input int w);
      return w * t;
   endfunction

   // Beat index width; a single-coefficient frame still needs one bit
   function automatic int idx_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/coeff_loader_if.sv
// Coefficient stream and packed-bank interface between the control side
// (master) and the loader (slave).
// Signals: s_valid/s_ready/s_data/s_last beat stream, packed_coeffs active
// bank, loaded/frame_err pulses, busy; commit_stb only with
// COEFF_LOADER_SYNC_COMMIT_EN defined.
interface coeff_loader_if #(
   parameter int N           = 3,
   parameter int COEFF_WIDTH = 16
);
   logic                           s_valid;
   logic                           s_ready;
   logic [COEFF_WIDTH-1:0]         s_data;
   logic                           s_last;
   logic [COEFF_WIDTH*(N+1)-1:0]   packed_coeffs;
   logic                           loaded;
   logic                           frame_err;
   logic                           busy;
`ifdef COEFF_LOADER_SYNC_COMMIT_EN
   logic                           commit_stb;

   modport master (
      output s_valid, s_data, s_last, commit_stb,
      input  s_ready, packed_coeffs, loaded, frame_err, busy
   );
   modport slave (
      input  s_valid, s_data, s_last, commit_stb,
      output s_ready, packed_coeffs, loaded, frame_err, busy
   );
`else
   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, packed_coeffs, loaded, frame_err, busy
   );
   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, packed_coeffs, loaded, frame_err, busy
   );
`endif
endinterface

// File: rtl/coeff_loader_bank.sv
// Register bank of N+1 coefficient words with per-word write and bulk load.
// Ports: clk/rst, i_we per-word enables with shared i_wdat, i_load/i_load_dat
// bulk load (wins over word writes), o_dat packed contents.
module coeff_bank
   import dsp_pkg::*;
#(
   parameter int                           N           = 3,
   parameter int                           COEFF_WIDTH = 16,
   parameter logic [COEFF_WIDTH*(N+1)-1:0] RESET_VAL   = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N:0]                     i_we,
   input  logic [COEFF_WIDTH-1:0]         i_wdat,
   input  logic                           i_load,
   input  logic [COEFF_WIDTH*(N+1)-1:0]   i_load_dat,
   output logic [COEFF_WIDTH*(N+1)-1:0]   o_dat
);

   logic [COEFF_WIDTH*(N+1)-1:0] r_dat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dat <= RESET_VAL;
      end else if (i_load) begin
         r_dat <= i_load_dat;
      end else begin
         for (int k = 0; k <= N; k++) begin
            if (i_we[k]) begin
               r_dat[slice_off(k, COEFF_WIDTH) +: COEFF_WIDTH] <= i_wdat;
            end
         end
      end
   end

   assign o_dat = r_dat;

endmodule

// File: rtl/coeff_loader.sv
// Streams N+1 signed coefficients into a shadow bank, checks frame length and
// swaps the shadow into the active bank in one step, so the filter never sees
// a partial set. Latency: last beat at edge T -> packed_coeffs at edge T+1.
// Ports: clk, rst (async, active-high), bus (coeff_loader_if.slave).
// Option COEFF_LOADER_SYNC_COMMIT_EN: COMMIT waits for bus.commit_stb.
module coeff_loader
   import dsp_pkg::*;
#(
   parameter int                           N            = 3,
   parameter int                           COEFF_WIDTH  = 16,
   parameter logic [COEFF_WIDTH*(N+1)-1:0] RESET_COEFFS = '0
) (
   input  logic           clk,
   input  logic           rst,
   coeff_loader_if.slave  bus
);

   localparam int IW = idx_width(N);
   localparam int W  = COEFF_WIDTH * (N + 1);

   state_t         r_state, w_state_nxt;
   logic [IW-1:0]  r_idx, w_idx_nxt;
   logic           r_loaded, r_frame_err;

   logic           w_beat;
   logic           w_ready, w_busy;
   logic           w_sh_wr;
   logic [IW-1:0]  w_sh_widx;
   logic           w_sh_restore;
   logic           w_commit;
   logic           w_err;
   logic [N:0]     w_sh_we;
   logic [W-1:0]   w_shadow, w_active;
   logic           w_commit_go;

`ifdef COEFF_LOADER_SYNC_COMMIT_EN
   assign w_commit_go = bus.commit_stb;
`else
   assign w_commit_go = 1'b1;
`endif

   assign w_beat = bus.s_valid && w_ready;

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_ready      = 1'b1;
      w_busy       = 1'b1;
      w_sh_wr      = 1'b0;
      w_sh_widx    = r_idx;
      w_sh_restore = 1'b0;
      w_commit     = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_busy    = 1'b0;
            w_sh_widx = '0;
            if (w_beat) begin
               if (!bus.s_last) begin
                  w_sh_wr   = 1'b1;
                  w_idx_nxt = IW'(1);
                  // A one-word frame cannot continue: an unterminated first
                  // beat is already too long.
                  w_state_nxt = (N == 0) ? ST_DRAIN : ST_LOAD;
               end else if (N == 0) begin
                  w_sh_wr     = 1'b1;
                  w_state_nxt = ST_COMMIT;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (w_beat) begin
               w_sh_wr = 1'b1;
               if (r_idx == IW'(N)) begin
                  w_state_nxt = bus.s_last ? ST_COMMIT : ST_DRAIN;
               end else if (bus.s_last) begin
                  w_err        = 1'b1;
                  w_sh_restore = 1'b1;
                  w_idx_nxt    = '0;
                  w_state_nxt  = ST_IDLE;
               end else begin
                  w_idx_nxt = r_idx + IW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (w_beat && bus.s_last) begin
               w_err        = 1'b1;
               w_sh_restore = 1'b1;
               w_idx_nxt    = '0;
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_COMMIT: begin
            w_ready = 1'b0;
            if (w_commit_go) begin
               w_commit    = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // One-hot word enable for the shadow write (restore takes priority in the bank)
   always_comb begin
      w_sh_we = '0;
      for (int k = 0; k <= N; k++) begin
         w_sh_we[k] = w_sh_wr && (w_sh_widx == IW'(k));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_loaded    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_loaded    <= w_commit;
         r_frame_err <= w_err;
      end
   end

   coeff_bank #(
      .N           (N),
      .COEFF_WIDTH (COEFF_WIDTH),
      .RESET_VAL   (RESET_COEFFS)
   ) u_shadow (
      .clk         (clk),
      .rst         (rst),
      .i_we        (w_sh_we),
      .i_wdat      (bus.s_data),
      .i_load      (w_sh_restore),
      .i_load_dat  (w_active),
      .o_dat       (w_shadow)
   );

   // Active bank only ever takes the whole shadow at commit
   coeff_bank #(
      .N           (N),
      .COEFF_WIDTH (COEFF_WIDTH),
      .RESET_VAL   (RESET_COEFFS)
   ) u_active (
      .clk         (clk),
      .rst         (rst),
      .i_we        ('0),
      .i_wdat      ('0),
      .i_load      (w_commit),
      .i_load_dat  (w_shadow),
      .o_dat       (w_active)
   );

   assign bus.s_ready       = w_ready;
   assign bus.busy          = w_busy;
   assign bus.loaded        = r_loaded;
   assign bus.frame_err     = r_frame_err;
   assign bus.packed_coeffs = w_active;

endmodule

// File: tb/tb_coeff_loader.sv
// Randomised scoreboard bench for coeff_loader (N=3, COEFF_WIDTH=16).
module tb_coeff_loader;

   localparam int N  = 3;
   localparam int CW = 16;
   localparam int W  = CW * (N + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   coeff_loader_if #(.N(N), .COEFF_WIDTH(CW)) ifc();

   coeff_loader #(
      .N            (N),
      .COEFF_WIDTH  (CW),
      .RESET_COEFFS ({W{1'b0}})
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   typedef struct {
      bit           is_err;
      logic [W-1:0] coeffs;
      int           cyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [CW-1:0] frm[$];
   logic [W-1:0]  model_active;
   int            vec = 0;
   int            mis = 0;
   int            cyc = 0;
   int            gap_pct = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vec++;
      if (act !== req) begin
         mis++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      vec++;
      mis++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // Reference: coefficient t of the frame lands in slice t, bit exact
   function automatic logic [W-1:0] pack_frame();
      logic [W-1:0] r;
      r = '0;
      for (int t = 0; t < frm.size(); t++) r[CW*t +: CW] = frm[t];
      return r;
   endfunction

   task automatic make_frame(input int len);
      frm.delete();
      repeat (len) frm.push_back(CW'($urandom()));
   endtask

   // Monitor: every loaded/frame_err pulse must match the next expected event
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (ifc.loaded || ifc.frame_err)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", 64'({ifc.loaded, ifc.frame_err}), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("pulse_kind", 64'({ifc.loaded, ifc.frame_err}), e.is_err ? 64'd1 : 64'd2);
               check("pulse_cycle", 64'(cyc), 64'(e.cyc));
               check("active_bank", ifc.packed_coeffs, e.coeffs);
            end
         end
      end
   end

   // Drive one beat; returns the clock edge number on which it transfers
   task automatic drive_beat(input logic [CW-1:0] d, input bit last, output int edge_no);
      int   guard;
      logic r0;
      guard   = 0;
      edge_no = -1;
      while (guard < 200) begin
         @(negedge clk);
         guard++;
         if ($urandom_range(99) < gap_pct) begin
            ifc.s_valid = 1'b0;
         end else begin
            r0 = ifc.s_ready;
            ifc.s_valid = 1'b1;
            ifc.s_data  = d;
            ifc.s_last  = last;
            #1;
            check("ready_indep_valid", 64'(ifc.s_ready), 64'(r0));
            if (ifc.s_ready) begin
               edge_no = cyc + 1;
               break;
            end
         end
      end
      if (edge_no < 0) timeout_fail("beat_timeout");
   endtask

   // Send frm; abort_after>0 stops after that many beats (no event expected)
   task automatic send_frame(input int delay, input int abort_after);
      int t;
      int n;
      n = frm.size();
      t = 0;
`ifdef COEFF_LOADER_SYNC_COMMIT_EN
      if (delay > 0) ifc.commit_stb = 1'b0;
`endif
      for (int k = 0; k < n; k++) begin
         drive_beat(frm[k], k == n - 1, t);
         if (abort_after > 0 && k + 1 == abort_after) return;
      end
      if (n == N + 1) begin
         model_active = pack_frame();
         exp_q.push_back('{is_err: 1'b0, coeffs: model_active, cyc: t + 1 + delay});
      end else begin
         exp_q.push_back('{is_err: 1'b1, coeffs: model_active, cyc: t});
      end
      @(negedge clk);
      ifc.s_valid = 1'b0;
      if (n == N + 1) begin
         check("commit_ready_low", 64'(ifc.s_ready), 64'd0);
         check("commit_busy", 64'(ifc.busy), 64'd1);
`ifdef COEFF_LOADER_SYNC_COMMIT_EN
         if (delay > 0) begin
            repeat (delay) @(negedge clk);
            check("hold_ready_low", 64'(ifc.s_ready), 64'd0);
            ifc.commit_stb = 1'b1;
         end
`endif
      end else begin
         check("err_ready", 64'(ifc.s_ready), 64'd1);
         check("err_idle", 64'(ifc.busy), 64'd0);
      end
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 50) begin
         @(negedge clk);
         g++;
      end
      @(negedge clk);
      if (exp_q.size() != 0) begin
         timeout_fail("drain_timeout");
         exp_q.delete();
      end
   endtask

   initial begin
      int len;
      ifc.s_valid  = 1'b0;
      ifc.s_data   = '0;
      ifc.s_last   = 1'b0;
`ifdef COEFF_LOADER_SYNC_COMMIT_EN
      ifc.commit_stb = 1'b1;
`endif
      model_active = '0;

      repeat (3) @(negedge clk);
      check("rst_coeffs", ifc.packed_coeffs, 64'd0);
      check("rst_ready", 64'(ifc.s_ready), 64'd1);
      check("rst_busy", 64'(ifc.busy), 64'd0);
      check("rst_loaded", 64'(ifc.loaded), 64'd0);
      check("rst_frame_err", 64'(ifc.frame_err), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed good frame
      frm = '{16'h4000, 16'hC000, 16'h2000, 16'h0100};
      send_frame(0, 0);
      wait_drain();
      check("directed_value", ifc.packed_coeffs, 64'h0100_2000_C000_4000);

      // Short frame leaves the active bank alone
      make_frame(3);
      send_frame(0, 0);
      wait_drain();
      check("short_unchanged", ifc.packed_coeffs, 64'h0100_2000_C000_4000);
      make_frame(4);
      send_frame(0, 0);
      wait_drain();

      // Long frame is drained and rejected
      make_frame(6);
      send_frame(0, 0);
      wait_drain();
      check("long_unchanged", ifc.packed_coeffs, model_active);

      // Good frame with roughly half the cycles idle
      gap_pct = 50;
      make_frame(4);
      send_frame(0, 0);
      wait_drain();
      gap_pct = 0;

      // Asynchronous reset after beat 2
      make_frame(4);
      send_frame(0, 2);
      @(posedge clk);
      #2;
      ifc.s_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("arst_coeffs", ifc.packed_coeffs, 64'd0);
      check("arst_ready", 64'(ifc.s_ready), 64'd1);
      check("arst_busy", 64'(ifc.busy), 64'd0);
      check("arst_frame_err", 64'(ifc.frame_err), 64'd0);
      model_active = '0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      make_frame(4);
      send_frame(0, 0);
      wait_drain();

`ifdef COEFF_LOADER_SYNC_COMMIT_EN
      make_frame(4);
      send_frame(5, 0);
      wait_drain();
`endif

      // Randomised frames, biased towards correct length
      for (int i = 0; i < 40; i++) begin
         len = ($urandom_range(1) == 1) ? 4 : int'($urandom_range(1, 6));
         gap_pct = int'($urandom_range(0, 60));
         make_frame(len);
         send_frame(0, 0);
      end
      gap_pct = 0;
      wait_drain();
      check("final_bank", ifc.packed_coeffs, model_active);

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
- Streaming writer for the packed coefficient bus that feeds the direct form I filter pipeline (`packed_coeffs`, COEFF_WIDTH*(N+1) bits, h[0] in the LSB slice).
- Accepts N+1 signed coefficients over a valid/ready stream into a shadow bank, validates the frame length, then swaps the shadow bank into the active bank atomically.
- The filter therefore never sees a partially written coefficient set.
- Sits between the control/register interface and the filter instance.

Parameters:
- N, 3, filter order; frame length is N+1 coefficients.
- COEFF_WIDTH, 16, bits per signed coefficient.
- RESET_COEFFS, 0, (COEFF_WIDTH*(N+1))-bit value loaded into the active and shadow banks on reset.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  coefficient beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  COEFF_WIDTH  signed coefficient; beat k of a frame is h[k].
- s_last  in  1  marks the final beat of a frame.
- packed_coeffs  out  COEFF_WIDTH*(N+1)  active bank; slice t = [COEFF_WIDTH*t +: COEFF_WIDTH] holds h[t].
- loaded  out  1  one-cycle pulse, asserted on the cycle the active bank changes.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- busy  out  1  high while a frame is partially received, draining, or committing.

Behaviour:
- Clocking/reset: one clock domain. `rst` is asynchronous and active-high.
  - On reset: `packed_coeffs` = RESET_COEFFS, shadow = RESET_COEFFS, index = 0, state = IDLE, `s_ready` = 1.
  - On reset: `loaded`, `frame_err` and `busy` = 0.
- Handshake: a beat transfers on a rising edge with `s_valid` && `s_ready`. `s_ready` is combinational from state only, never from `s_valid`.
- Index counter: width $clog2(N+1), minimum 1. It counts accepted beats within the frame.
- States:
  - IDLE: `s_ready`=1, `busy`=0.
    - Beat with `s_last`=0: write shadow[0], index=1, go to LOAD.
    - Beat with `s_last`=1: if N==0 go to COMMIT, else pulse `frame_err` and stay in IDLE.
  - LOAD: `s_ready`=1, `busy`=1. On a beat, write shadow[index].
    - index<N and `s_last`=1: short frame. Pulse `frame_err`, restore shadow from the active bank, go to IDLE.
    - index<N and `s_last`=0: index++.
    - index==N and `s_last`=1: go to COMMIT.
    - index==N and `s_last`=0: long frame. Go to DRAIN.
  - DRAIN: `s_ready`=1, `busy`=1. Beats are discarded.
    - On the beat with `s_last`=1: pulse `frame_err`, restore shadow from the active bank, go to IDLE.
  - COMMIT: `s_ready`=0, `busy`=1, exactly one cycle (without the optional feature).
    - At its closing edge: `packed_coeffs` <= shadow, `loaded` pulses on the following cycle, index=0, go to IDLE.
- Latency: the final beat is accepted at edge T; `packed_coeffs` updates at edge T+1.
- The active bank changes only in COMMIT; a rejected frame never alters it.
- The maximum rate is one frame per N+2 cycles.
- Reset mid-frame: shadow returns to RESET_COEFFS and the active bank returns to RESET_COEFFS. No `frame_err` pulse.
- Coefficients are stored bit-exact. No sign extension, scaling or negation is applied here; F/Q scaling stays in the filter.

Optional Feature:
- Macro: COEFF_LOADER_SYNC_COMMIT_EN.
- Defined:
  - Adds input `commit_stb` (1 bit), a sample-boundary strobe.
  - COMMIT holds (`s_ready`=0, `busy`=1) until `commit_stb`=1, then swaps on that edge.
  - If `commit_stb` is already high on entry, the swap happens one cycle after entry, as in the undefined case.
- Undefined:
  - No `commit_stb` port; COMMIT always lasts one cycle.

Decomposition:
- Package `dsp_pkg`:
  - state encoding localparams (ST_IDLE, ST_LOAD, ST_DRAIN, ST_COMMIT);
  - a helper function for slice offset (`COEFF_WIDTH*t`);
  - the `$clog2`-based index width function.
- One natural sub-module: `coeff_bank`, a register bank of N+1 COEFF_WIDTH-wide words with:
  - a per-word write enable;
  - bulk load from a packed vector;
  - a packed output.
- It is instantiated twice (shadow and active); the FSM stays in `coeff_loader`.

Test Plan (N=3, COEFF_WIDTH=16):
- Reset with RESET_COEFFS=0 -> `packed_coeffs`=0, `s_ready`=1, `busy`=0, `loaded`=0, `frame_err`=0.
- Frame 0x4000,0xC000,0x2000,0x0100 with `s_last` on beat 4 -> `packed_coeffs`=64'h0100_2000_C000_4000 exactly one cycle after beat 4; `loaded` pulses once; `s_ready` is low for one cycle.
- Short frame (3 beats, `s_last` on beat 3) after a good load -> `frame_err` pulses once and `packed_coeffs` is unchanged; the next good frame loads correctly.
- Long frame (6 beats, `s_last` on beat 6) -> beats 5-6 are accepted and discarded, `frame_err` pulses on the cycle after beat 6, and the active bank is unchanged.
- `s_valid` toggled randomly (about 50%) during a good frame -> the same result as back-to-back beats; `s_ready` never depends on `s_valid`.
- `rst` asserted asynchronously after beat 2 -> outputs go to reset values immediately; a fresh 4-beat frame afterwards loads correctly. With COEFF_LOADER_SYNC_COMMIT_EN defined, `commit_stb` withheld for 5 cycles -> the swap occurs on the `commit_stb` edge.
